load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the 64-bit word-addressed data memory. Converts byte-addressed RV64I loads and stores (B/H/W/D, signed and unsigned) into whole-word memory accesses.
- Sub-doubleword stores use a read-modify-write sequence.
- Load results are sign- or zero-extended to 64 bits.
- Handshake with the datapath is REQ/DONE, held off by BUSY.

Parameters:
- SIZE, 64, data word width. The block only supports 64.
- N, 32, number of memory words. Word address width is $clog2(N); byte address width is AW = $clog2(N)+3.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- REQ  input  1  start an access. Sampled only in IDLE.
- STORE  input  1  1 = store, 0 = load. Sampled with REQ.
- FUNCT3  input  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- ADDR  input  AW  byte address.
- D_WR  input  SIZE  store data. Low bytes are used.
- D_RD  output  SIZE  extended load result.
- BUSY  output  1  high whenever state is not IDLE.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  valid with DONE: access rejected.
- MEM_ADDR  output  $clog2(N)  word address to the data memory.
- MEM_WE  output  1  data memory write enable.
- MEM_DIN  output  SIZE  data memory write data.
- MEM_DOUT  input  SIZE  data memory read data. Combinational from MEM_ADDR.

Behaviour:
- Reset (RST_N low at a CLK edge): state IDLE; D_RD=0, DONE=0, ERR=0, BUSY=0, MEM_WE=0; latched request cleared.
  - Reset mid-operation aborts the access. No write occurs after reset is asserted.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: on REQ=1, latch STORE/FUNCT3/ADDR/D_WR and go to ACCESS.
  - If the request is invalid, latch ERR=1 and go to RESP instead.
  - Invalid means: load FUNCT3=111, store FUNCT3[2]=1, or misaligned (see Optional Feature).
- ACCESS: MEM_ADDR = latched ADDR[AW-1:3].
  - Load: extract the bytes at offset ADDR[2:0] (little-endian), extend per FUNCT3, register into D_RD, go to RESP.
  - Store: merge the size-masked D_WR bytes into MEM_DOUT at the offset; register the merged word; go to WRITE.
- WRITE: MEM_WE=1 for exactly one cycle, MEM_ADDR as in ACCESS, MEM_DIN = merged word. Go to RESP.
- RESP: DONE=1 for one cycle, ERR valid. Go to IDLE.
- Latency, REQ edge to DONE high: load 2 cycles, store 3 cycles, error 1 cycle. Back-to-back: the next REQ is accepted in the cycle after RESP.
- REQ while BUSY is ignored. The datapath holds REQ until DONE.
- D_RD holds its value until the next successful load completes. Stores and errors leave D_RD unchanged.
- MEM_WE=0 in every state except WRITE. MEM_ADDR=0 and MEM_DIN=0 in IDLE.
- Extension: LB/LH/LW sign-extend from bit 7/15/31 of the extracted field. LBU/LHU/LWU zero-extend. LD passes the word unchanged.
- Byte lanes: SB writes lane ADDR[2:0]. SH writes lanes off, off+1. SW writes lanes off..off+3. SD writes all lanes. Untouched lanes retain their old memory bytes.
- Highest word (MEM_ADDR = N-1) needs no special case; there is no wrap to word 0.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: an access is misaligned when ADDR[0]≠0 (H), ADDR[1:0]≠0 (W), or ADDR[2:0]≠0 (D). Misaligned requests complete with DONE=1, ERR=1, no memory read and no write.
- Undefined: offset bits below the access size are forced to zero (address aligned down), the access proceeds normally, and ERR is asserted only for invalid FUNCT3.

Test Plan:
- Preload word 16 = 0x2DA. LB at ADDR=128 → DONE at +2 cycles, D_RD=0xFFFFFFFFFFFFFFDA, ERR=0. LBU at 128 → D_RD=0x00000000000000DA.
- SH D_WR=0x1234BEEF at ADDR=130 → MEM_WE high exactly one cycle (cycle +2), MEM_ADDR=16, MEM_DIN=0x00000000BEEF02DA. Then LD at 128 returns 0x00000000BEEF02DA.
- SD 0x0123456789ABCDEF at ADDR=248 (word 31) → word 31 written in full. LW at 252 → 0x0000000001234567. LWU at 248 → 0x0000000089ABCDEF.
- With MISALIGN_TRAP_EN: LW at ADDR=130 → DONE+ERR at +1 cycle, MEM_WE never asserted, D_RD unchanged. Without the macro: same request reads bytes 128–131 → 0xFFFFFFFFBEEF02DA after the SH scenario.
- Store FUNCT3=100 → ERR=1, no write. REQ pulsed while BUSY during an SB → ignored; exactly one DONE observed.
- RST_N=0 during ACCESS of an SB to word 21 (preloaded 312) → no MEM_WE ever asserted, word 21 still 312, all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Datapath and data-memory signal bundle for load_store_unit.
// The master side is the execute stage plus the memory; the slave side is the LSU.
interface load_store_unit_if #(
  parameter int SIZE = 64,
  parameter int N    = 32
);
  localparam int WA = $clog2(N);
  localparam int AW = WA + 3;

  // Handshake: the datapath raises req with store/funct3/addr/d_wr stable and holds it
  // until done; req is only sampled while busy is low; done is a one-cycle pulse and
  // err/d_rd are valid in that cycle.
  logic            req;
  logic            store;
  logic [2:0]      funct3;
  logic [AW-1:0]   addr;
  logic [SIZE-1:0] d_wr;
  logic [SIZE-1:0] d_rd;
  logic            busy;
  logic            done;
  logic            err;
  logic [WA-1:0]   mem_addr;
  logic            mem_we;
  logic [SIZE-1:0] mem_din;
  logic [SIZE-1:0] mem_dout;

  modport master (
    output req, store, funct3, addr, d_wr, mem_dout,
    input  d_rd, busy, done, err, mem_addr, mem_we, mem_din
  );

  modport slave (
    input  req, store, funct3, addr, d_wr, mem_dout,
    output d_rd, busy, done, err, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64I byte-addressed load/store unit over a 64-bit word memory, RMW for narrow stores.
// Define MISALIGN_TRAP_EN to reject misaligned accesses; otherwise they are aligned down.
module load_store_unit #(
  parameter int SIZE = 64,
  parameter int N    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus,
  output logic [1:0]        fsm_state
);
  localparam int WA = $clog2(N);
  localparam int AW = WA + 3;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t          state;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [2:0]      off_q;
  logic [SIZE-1:0] wdata_q;
  logic [SIZE-1:0] d_rd_q;
  logic [SIZE-1:0] din_q;
  logic [WA-1:0]   maddr_q;
  logic            we_q;
  logic            done_q;
  logic            err_q;
  logic            busy_q;

  logic [2:0]      low_mask;
  logic            req_bad;
  logic [AW-1:0]   req_addr;

  always_comb begin
    unique case (bus.funct3[1:0])
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
    req_bad  = bus.store ? bus.funct3[2] : (bus.funct3 == 3'b111);
    req_addr = bus.addr;
`ifdef MISALIGN_TRAP_EN
    if ((bus.addr[2:0] & low_mask) != 3'b000) req_bad = 1'b1;
`else
    req_addr[2:0] = bus.addr[2:0] & ~low_mask;
`endif
  end

  logic [5:0]      shamt;
  logic [SIZE-1:0] field;
  logic [SIZE-1:0] load_val;
  logic [SIZE-1:0] store_sh;
  logic [SIZE-1:0] merged;
  logic [7:0]      lane_en;

  always_comb begin
    shamt = {off_q, 3'b000};
    field = bus.mem_dout >> shamt;
    unique case (funct3_q)
      3'b000:  load_val = {{(SIZE-8){field[7]}},   field[7:0]};
      3'b001:  load_val = {{(SIZE-16){field[15]}}, field[15:0]};
      3'b010:  load_val = {{(SIZE-32){field[31]}}, field[31:0]};
      3'b100:  load_val = {{(SIZE-8){1'b0}},       field[7:0]};
      3'b101:  load_val = {{(SIZE-16){1'b0}},      field[15:0]};
      3'b110:  load_val = {{(SIZE-32){1'b0}},      field[31:0]};
      default: load_val = field;
    endcase
    unique case (funct3_q[1:0])
      2'd0:    lane_en = 8'h01 << off_q;
      2'd1:    lane_en = 8'h03 << off_q;
      2'd2:    lane_en = 8'h0F << off_q;
      default: lane_en = 8'hFF;
    endcase
    store_sh = wdata_q << shamt;
    merged   = bus.mem_dout;
    for (int i = 0; i < 8; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = store_sh[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 3'b000;
      wdata_q  <= '0;
      d_rd_q   <= '0;
      din_q    <= '0;
      maddr_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus.req) begin
            store_q  <= bus.store;
            funct3_q <= bus.funct3;
            off_q    <= req_addr[2:0];
            wdata_q  <= bus.d_wr;
            busy_q   <= 1'b1;
            if (req_bad) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= RESP;
            end else begin
              maddr_q <= req_addr[AW-1:3];
              state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (store_q) begin
            din_q <= merged;
            we_q  <= 1'b1;
            state <= WRITE;
          end else begin
            d_rd_q  <= load_val;
            maddr_q <= '0;
            done_q  <= 1'b1;
            state   <= RESP;
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          din_q   <= '0;
          maddr_q <= '0;
          done_q  <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write enable is also masked by reset so a reset landing in WRITE cannot commit.
  assign bus.mem_we   = we_q & rst_n;
  assign bus.mem_addr = maddr_q;
  assign bus.mem_din  = din_q;
  assign bus.d_rd     = d_rd_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign fsm_state    = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory model feeding
// an expected-result queue that is drained as each access completes.
module tb_load_store_unit;
  logic clk;
  logic rst_n;
  logic [1:0] fsm_state;

  load_store_unit_if #(.SIZE(64), .N(32)) bus ();

  load_store_unit #(.SIZE(64), .N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory and preload port
  logic [63:0] mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [63:0] pre_data;

  assign bus.mem_dout = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
  end

  // scoreboard
  logic [63:0] ref_mem [32];
  logic [63:0] exp_q[$];
  logic        err_q[$];
  logic [63:0] last_drd;
  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  task automatic preload(input int w, input logic [63:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 5'(w);
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
    ref_mem[w] = data;
  endtask

  task automatic do_access(input logic st, input logic [2:0] f3, input logic [7:0] a,
                           input logic [63:0] wd, input bit pulse, input string tag);
    int n, w, o, lat_exp, cyc, we_cnt, we_cyc, guard;
    logic bad, done_seen, exp_err;
    logic [63:0] v, exp_din, we_din, exp_drd;
    logic [4:0]  we_addr;
    logic [7:0]  ea;
    n   = 1 << f3[1:0];
    bad = st ? f3[2] : (f3 == 3'b111);
    ea  = a;
`ifdef MISALIGN_TRAP_EN
    if ((int'(a) % n) != 0) bad = 1'b1;
`else
    ea = a - 8'(int'(a) % n);
`endif
    w = int'(ea) / 8;
    o = int'(ea) % 8;
    exp_din = ref_mem[w];
    if (bad) begin
      lat_exp = 1;
    end else if (st) begin
      for (int k = 0; k < n; k++) exp_din[8*(o+k) +: 8] = wd[8*k +: 8];
      ref_mem[w] = exp_din;
      lat_exp = 3;
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[w][8*(o+k) +: 8];
      if (!f3[2] && n < 8 && v[8*n-1]) begin
        for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
      end
      last_drd = v;
      lat_exp = 2;
    end
    exp_q.push_back(last_drd);
    err_q.push_back(bad);

    @(negedge clk);
    guard = 0;
    while (bus.busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    bus.req = 1'b1; bus.store = st; bus.funct3 = f3; bus.addr = a; bus.d_wr = wd;
    cyc = 0; we_cnt = 0; we_cyc = 0; we_addr = '0; we_din = '0; done_seen = 1'b0;
    while (!done_seen && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.mem_we) begin
        we_cnt++; we_cyc = cyc; we_addr = bus.mem_addr; we_din = bus.mem_din;
      end
      if (bus.done) done_seen = 1'b1;
      else if (pulse) bus.req = ~bus.req;
    end
    bus.req = 1'b0;
    exp_drd = exp_q.pop_front();
    exp_err = err_q.pop_front();
    check({tag, "_done"}, done_seen, 1'b1);
    check({tag, "_lat"}, cyc, lat_exp);
    check({tag, "_drd"}, bus.d_rd, exp_drd);
    check({tag, "_err"}, bus.err, exp_err);
    check({tag, "_we_cnt"}, we_cnt, (st && !bad) ? 1 : 0);
    if (st && !bad) begin
      check({tag, "_we_cyc"}, we_cyc, 2);
      check({tag, "_we_addr"}, we_addr, w);
      check({tag, "_we_din"}, we_din, exp_din);
    end
    if (pulse) begin
      @(posedge clk); #1;
      check({tag, "_one_done"}, bus.done, 1'b0);
      check({tag, "_idle"}, bus.busy, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we_seen;
    logic [63:0] rd;
    n_tests = 0; n_fail = 0; last_drd = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req = 1'b0; bus.store = 1'b0; bus.funct3 = 3'b000; bus.addr = '0; bus.d_wr = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});
    preload(16, 64'h2DA);
    preload(21, 64'd312);
    @(posedge clk); #1;
    check("rst_drd", bus.d_rd, 64'd0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_maddr", bus.mem_addr, 5'd0);
    check("rst_mdin", bus.mem_din, 64'd0);
    check("rst_state", fsm_state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_access(1'b0, 3'b000, 8'd128, 64'd0, 1'b0, "lb_128");
    check("lb_128_const", bus.d_rd, 64'hFFFFFFFFFFFFFFDA);
    do_access(1'b0, 3'b100, 8'd128, 64'd0, 1'b0, "lbu_128");
    check("lbu_128_const", bus.d_rd, 64'h00000000000000DA);
    do_access(1'b1, 3'b001, 8'd130, 64'h1234BEEF, 1'b0, "sh_130");
    do_access(1'b0, 3'b011, 8'd128, 64'd0, 1'b0, "ld_128");
    check("ld_128_const", bus.d_rd, 64'h00000000BEEF02DA);
    do_access(1'b1, 3'b011, 8'd248, 64'h0123456789ABCDEF, 1'b0, "sd_248");
    do_access(1'b0, 3'b010, 8'd252, 64'd0, 1'b0, "lw_252");
    check("lw_252_const", bus.d_rd, 64'h0000000001234567);
    do_access(1'b0, 3'b110, 8'd248, 64'd0, 1'b0, "lwu_248");
    check("lwu_248_const", bus.d_rd, 64'h0000000089ABCDEF);
    do_access(1'b0, 3'b010, 8'd130, 64'd0, 1'b0, "lw_130");
`ifdef MISALIGN_TRAP_EN
    check("lw_130_const", bus.d_rd, 64'h0000000089ABCDEF);
`else
    check("lw_130_const", bus.d_rd, 64'hFFFFFFFFBEEF02DA);
`endif
    do_access(1'b1, 3'b100, 8'd64, 64'hFFFF, 1'b0, "st_bad_f3");
    do_access(1'b0, 3'b111, 8'd64, 64'd0, 1'b0, "ld_bad_f3");
    do_access(1'b1, 3'b000, 8'd43, 64'hA5, 1'b1, "sb_pulse");
    do_access(1'b0, 3'b101, 8'd42, 64'd0, 1'b0, "lhu_42");

    for (int i = 0; i < 24; i++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                {$urandom, $urandom}, 1'b0, "rand");
    end

    // reset landing in ACCESS of an SB to word 21
    @(negedge clk);
    while (bus.busy) @(negedge clk);
    bus.req = 1'b1; bus.store = 1'b1; bus.funct3 = 3'b000; bus.addr = 8'd169; bus.d_wr = 64'hAB;
    @(posedge clk); #1;
    we_seen = bus.mem_we;
    check("abort_in_access", fsm_state, 2'd1);
    rst_n = 1'b0;
    bus.req = 1'b0;
    @(posedge clk); #1;
    we_seen = we_seen | bus.mem_we;
    check("abort_drd", bus.d_rd, 64'd0);
    check("abort_done", bus.done, 1'b0);
    check("abort_err", bus.err, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_maddr", bus.mem_addr, 5'd0);
    check("abort_mdin", bus.mem_din, 64'd0);
    check("abort_state", fsm_state, 2'd0);
    repeat (3) begin
      @(posedge clk); #1;
      we_seen = we_seen | bus.mem_we;
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_drd = '0;
    check("abort_no_we", we_seen, 1'b0);
    rd = mem[21];
    check("abort_word21", rd, 64'd312);

    do_access(1'b0, 3'b011, 8'd168, 64'd0, 1'b0, "ld_168_after_rst");

    for (int i = 0; i < 32; i++) begin
      rd = mem[i];
      check("mem_final", rd, ref_mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
